// File: rtl/booth_r4_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_seq_mult
// Brief    : Sequential radix-4 Booth multiplier, two multiplier bits per clock,
//            per-transaction signed/unsigned mode, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module booth_r4_seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           signed_en,
    input  logic [N-1:0]   M,
    input  logic [N-1:0]   Q,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P,
    output logic           busy
);

    localparam int ITER = N / 2 + 1;
    localparam int XW   = N + 2;
    localparam int AW   = N + 4;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(ITER - 1);

    generate
        if ((N % 2) != 0 || N < 4) begin : g_bad_width
            $error("booth_r4_seq_mult: N must be even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CALC = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t          state_q;
    logic [XW-1:0]   m_q;
    logic [XW-1:0]   q_q;
    logic            qm1_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  p_q;

    logic [XW-1:0]   m_ext;
    logic [XW-1:0]   q_ext;
    logic [AW-1:0]   m_x;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   acc_d;
    logic [XW-1:0]   q_d;
    logic            qm1_d;

    // Extension to N+2 bits lets an unsigned operand be treated as a positive signed one.
    assign m_ext = signed_en ? {{2{M[N-1]}}, M} : {2'b00, M};
    assign q_ext = signed_en ? {{2{Q[N-1]}}, Q} : {2'b00, Q};

    always_comb begin
        m_x = {{2{m_q[XW-1]}}, m_q};
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: pp = m_x;
            3'b011:         pp = m_x << 1;
            3'b100:         pp = -(m_x << 1);
            3'b101, 3'b110: pp = -m_x;
            default:        pp = '0;
        endcase
        sum   = acc_q + pp;
        acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d   = {sum[1:0], q_q[XW-1:2]};
        qm1_d = q_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        m_q     <= m_ext;
                        q_q     <= q_ext;
                        qm1_q   <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_DIGIT) begin
                        p_q     <= {acc_d[N-3:0], q_d};
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign P         = p_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_r4_seq_mult
// Brief    : Scoreboard bench for booth_r4_seq_mult (N=8 main, N=4 exhaustive).
// Revision : 1.0
// ============================================================================
module tb_booth_r4_seq_mult;

    localparam int N   = 8;
    localparam int LAT = N / 2 + 1;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic           signed_en = 1'b0;
    logic [N-1:0]   M         = '0;
    logic [N-1:0]   Q         = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] P;
    logic           busy;

    logic           rst4_n = 1'b0;
    logic           iv4    = 1'b0;
    logic           ir4;
    logic           se4    = 1'b0;
    logic [3:0]     m4     = '0;
    logic [3:0]     q4     = '0;
    logic           ov4;
    logic           or4    = 1'b1;
    logic [7:0]     p4;
    logic           busy4;

    typedef struct {
        logic [15:0] p;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec      = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    bit   rand_ready = 1'b0;
    logic ov_prev    = 1'b0;

    booth_r4_seq_mult #(.N(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .signed_en(signed_en), .M(M), .Q(Q), .out_valid(out_valid),
        .out_ready(out_ready), .P(P), .busy(busy)
    );

    booth_r4_seq_mult #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4),
        .signed_en(se4), .M(m4), .Q(q4), .out_valid(ov4),
        .out_ready(or4), .P(p4), .busy(busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint model(input int n, input longint a, input longint b, input bit s);
        longint x;
        longint y;
        x = a;
        y = b;
        if (s && a >= (longint'(1) << (n - 1))) x = a - (longint'(1) << n);
        if (s && b >= (longint'(1) << (n - 1))) y = b - (longint'(1) << n);
        return (x * y) & ((longint'(1) << (2 * n)) - 1);
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'h7F;
            3:       return 8'h80;
            4:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
        int   w;
        exp_t e;
        w         = 0;
        M         = a;
        Q         = b;
        signed_en = s;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.p   = 16'(model(8, longint'(a), longint'(b), s));
        e.cyc = cyc;
        sb.push_back(e);
        in_valid  = 1'b0;
        M         = 8'($urandom);
        Q         = 8'($urandom);
        signed_en = 1'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
                else                chk("latency", 64'(cyc - sb[0].cyc), 64'(LAT));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_handshake", 64'd1, 64'd0);
                end else begin
                    chk("product", 64'(P), 64'(sb[0].p));
                    void'(sb.pop_front());
                end
            end
        end
        ov_prev = out_valid;
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ca [5];
        logic [7:0]  cb [5];
        logic        cs [5];
        logic [15:0] cp [5];
        ca = '{8'h80, 8'h80, 8'h7F, 8'hFF, 8'hFF};
        cb = '{8'h80, 8'h7F, 8'h7F, 8'hFF, 8'hFF};
        cs = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
        cp = '{16'h4000, 16'hC080, 16'h3F01, 16'hFE01, 16'h0001};

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_P",         64'(P),         64'd0);

        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'd3, 8'hFC, 1'b1);
        @(negedge clk);
        chk("calc_busy",     64'(busy),     64'd1);
        chk("calc_in_ready", 64'(in_ready), 64'd0);
        drain();
        @(negedge clk);
        chk("valid_one_cycle", 64'(out_valid), 64'd0);
        chk("p_3_times_m4",    64'(P),         64'hFFF4);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            send(ca[i], cb[i], cs[i]);
            drain();
            chk("corner", 64'(P), 64'(cp[i]));
        end

        // Output stall: product must hold and new operands must be ignored.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0);
        begin
            int w;
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
        end
        in_valid  = 1'b1;
        M         = 8'hAA;
        Q         = 8'h55;
        signed_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_P",         64'(P),         64'h03A8);
            chk("hold_in_ready",  64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        @(posedge clk);
        #1;
        send(8'h21, 8'h43, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_P",         64'(P),         64'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(8'd5, 8'd6, 1'b0);
        drain();
        chk("p_after_rst", 64'(P), 64'd30);

        rand_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(pick(), pick(), 1'($urandom));
        end
        drain();
        rand_ready = 1'b0;
        #20;

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    int w;
                    int acc_cyc;
                    @(posedge clk);
                    #1;
                    m4  = 4'(a);
                    q4  = 4'(b);
                    se4 = s[0];
                    iv4 = 1'b1;
                    w   = 0;
                    @(negedge clk);
                    while (!ir4 && w < 50) begin
                        @(negedge clk);
                        w++;
                    end
                    @(posedge clk);
                    #1;
                    iv4     = 1'b0;
                    acc_cyc = cyc;
                    w       = 0;
                    @(negedge clk);
                    chk("n4_busy", 64'(busy4), 64'd1);
                    while (!ov4 && w < 50) begin
                        @(negedge clk);
                        w++;
                    end
                    chk("n4_latency", 64'(cyc - acc_cyc), 64'd3);
                    chk("n4_product", 64'(p4), 64'(model(4, longint'(a), longint'(b), s[0])));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
